// File: rtl/alu_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer_if
// Bundles the three handshakes of the ALU command sequencer:
//   cmd_*  : tagged command push (valid/ready) from the command source
//   alu_*  : start/done handshake towards the tinyalu datapath
//   rsp_*  : tagged result return (valid/ready)
//   busy, cmd_count : status
// Modports:
//   slave  - the sequencer itself
//   master - the environment (command source, ALU and response sink)
// -----------------------------------------------------------------------------
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // command push
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [WIDTH-1:0]   cmd_a;
    logic [WIDTH-1:0]   cmd_b;
    logic [TAG_W-1:0]   cmd_tag;

    // ALU handshake
    logic               alu_start;
    logic [2:0]         alu_op;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic               alu_done;
    logic [2*WIDTH-1:0] alu_result;

    // response return
    logic               rsp_valid;
    logic               rsp_ready;
    logic [TAG_W-1:0]   rsp_tag;
    logic [2:0]         rsp_op;
    logic [2*WIDTH-1:0] rsp_result;
    logic               rsp_err;

    // status
    logic               busy;
    logic [CNT_W-1:0]   cmd_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        input  alu_done, alu_result,
        input  rsp_ready,
        output cmd_ready,
        output alu_start, alu_op, alu_a, alu_b,
        output rsp_valid, rsp_tag, rsp_op, rsp_result, rsp_err,
        output busy, cmd_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        output alu_done, alu_result,
        output rsp_ready,
        input  cmd_ready,
        input  alu_start, alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_tag, rsp_op, rsp_result, rsp_err,
        input  busy, cmd_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Command front-end for the tinyalu datapath. Tagged commands are buffered in
// a DEPTH-entry FIFO, issued to the ALU one at a time over start/done, and the
// tagged results are returned over a valid/ready response port. Opcode 000
// (no_op) completes locally without touching the ALU.
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high
//   bus    - alu_cmd_sequencer_if.slave (cmd_*, alu_*, rsp_*, busy, cmd_count)
//
// Optional feature:
//   ALU_CMD_TIMEOUT_EN - when defined, an ISSUE that sees no alu_done for
//   TIMEOUT cycles is abandoned and answered with rsp_err=1, rsp_result=0.
//   When undefined, ISSUE waits indefinitely and rsp_err is always 0.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    alu_cmd_sequencer_if.slave        bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("alu_cmd_sequencer: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("alu_cmd_sequencer: TIMEOUT must be >= 1");
    end

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    logic [2:0]         r_alu_op;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;

    logic [TAG_W-1:0]   r_rsp_tag;
    logic [2:0]         r_rsp_op;
    logic [2*WIDTH-1:0] r_rsp_result;
    logic               r_rsp_err;

    entry_t             w_head;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_head_noop;
    logic               w_tmo;

    assign w_head      = r_mem[r_rptr];
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_head_noop = (w_head.op == 3'b000);
    // cmd_ready depends only on occupancy, never on a same-cycle pop
    assign w_push      = bus.cmd_valid && !w_full;

    // -------------------------------------------------------------------------
    // ISSUE watchdog
    // -------------------------------------------------------------------------
`ifdef ALU_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts ISSUE cycles from 0; expiry on the TIMEOUT-th cycle keeps
    // alu_start high for exactly TIMEOUT cycles.
    always_ff @(posedge clk) begin
        if (reset || (r_state != S_ISSUE)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // alu_done is checked first in the datapath, so a done on the expiry
    // edge still completes normally.
    assign w_tmo = (r_state == S_ISSUE) && (r_tmo_cnt == TMO_LAST);
`else
    assign w_tmo = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_head_noop ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.alu_done || w_tmo) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = w_head_noop ? S_RESP : S_ISSUE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    // Storage needs no reset; emptiness is defined by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, tag: bus.cmd_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // ALU operand and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_tag    <= '0;
            r_rsp_op     <= '0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
        end else if (w_pop) begin
            // Response fields are staged at pop; they are only visible as a
            // response once the FSM reaches RESP. A no_op leaves result at 0.
            r_rsp_tag    <= w_head.tag;
            r_rsp_op     <= w_head.op;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            if (!w_head_noop) begin
                r_alu_op <= w_head.op;
                r_alu_a  <= w_head.a;
                r_alu_b  <= w_head.b;
            end
        end else if (r_state == S_ISSUE) begin
            if (bus.alu_done) begin
                r_rsp_result <= bus.alu_result;
            end else if (w_tmo) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.cmd_ready  = !w_full;
    assign bus.alu_start  = (r_state == S_ISSUE);
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_tag    = r_rsp_tag;
    assign bus.rsp_op     = r_rsp_op;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.busy       = (r_state != S_IDLE) || !w_empty;
    assign bus.cmd_count  = r_count;

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Synthesizable, parametrised command front-end for the tinyalu datapath. It accepts tagged ALU commands over a valid/ready port and buffers them in a DEPTH-entry FIFO. It drives the ALU start/done handshake one command at a time and returns tagged results over a valid/ready response port. It sits between a command source (bus bridge or test harness) and the ALU, replacing hand-driven stimulus with a generic, width-scalable engine.

## Interface
Parameters:
- WIDTH, 8, operand width; result is 2*WIDTH
- DEPTH, 4, command FIFO entries (power of two, >=2)
- TAG_W, 4, command tag width
- TIMEOUT, 64, max cycles waiting for alu_done (used only with ALU_CMD_TIMEOUT_EN)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_op  in  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul; others are forwarded unchanged
- cmd_a, cmd_b  in  WIDTH  operands
- cmd_tag  in  TAG_W  returned with the response
- alu_start  out  1  ALU start
- alu_op  out  3  ALU opcode
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_done  in  1  ALU completion
- alu_result  in  2*WIDTH  ALU result, valid when alu_done=1
- rsp_valid  out  1  response held
- rsp_ready  in  1  response consumed
- rsp_tag  out  TAG_W  tag of the completed command
- rsp_op  out  3  opcode of the completed command
- rsp_result  out  2*WIDTH  result
- rsp_err  out  1  timeout flag
- busy  out  1  FSM not IDLE, or FIFO not empty
- cmd_count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- FIFO push when cmd_valid && cmd_ready. cmd_ready = (count != DEPTH) and is independent of a same-cycle pop.
- FSM states:
  - IDLE: FIFO empty, stay. Otherwise pop the head and go to ISSUE, or to RESP if op == 000.
  - ISSUE: alu_start=1; alu_op/a/b are held stable from the popped entry. On alu_done=1, capture alu_result, set rsp_valid, deassert start, and go to RESP.
  - RESP: hold rsp_* until rsp_valid && rsp_ready. On that cycle, pop the next entry if the FIFO is non-empty (go to ISSUE or RESP per op). Otherwise go to IDLE.
- no_op completes locally: alu_start is never asserted; rsp_result = 0 and rsp_err = 0.
- alu_done outside ISSUE is ignored.
- Push and pop in the same cycle: both occur and cmd_count is unchanged. A push into a full FIFO cannot occur because cmd_ready=0.
- FIFO pointers wrap modulo DEPTH. Commands are strictly in order; one is outstanding at a time.

## Timing
- Reset values: cmd_ready=1, alu_start=0, alu_op/a/b=0, rsp_valid=0, rsp_tag/op/result=0, rsp_err=0, busy=0, cmd_count=0. State = IDLE; FIFO is emptied.
- Command accepted at edge E0 into an empty, idle block: cmd_count=1 after E0. Pop at E1. alu_start=1 after E1.
- alu_done sampled 1 at edge Ek: rsp_valid=1 and alu_start=0 after Ek. The ALU sees start low for at least one cycle between commands.
- Response handshake at edge Er with the FIFO non-empty: next alu_start=1 after Er. Minimum 2-cycle issue gap for single-cycle ops.
- Reset asserted mid-operation, sampled at any edge: all outputs return to reset values after that edge. The in-flight command and queued commands are discarded with no response.

## Configuration
- ALU_CMD_TIMEOUT_EN defined:
  - A cycle counter runs while in ISSUE.
  - If TIMEOUT cycles elapse with no alu_done, deassert alu_start and go to RESP with rsp_err=1 and rsp_result=0.
  - alu_done on the same edge as expiry wins, giving a normal completion.
- Not defined: no counter, rsp_err tied 0, ISSUE waits indefinitely, TIMEOUT unused.

## Test plan
- Reset, then push add A=8'h12 B=8'h34 tag=3, with alu_done one cycle after start -> rsp_result=16'h0046, rsp_tag=3, rsp_err=0; alu_start high for exactly 1 cycle.
- Push mul A=8'hFF B=8'hFF, with done 3 cycles after start -> rsp_result=16'hFE01; alu_op/a/b stable throughout start.
- Hold rsp_ready=0 and push 5 commands (DEPTH=4) -> cmd_ready=0 once cmd_count=4. Release rsp_ready -> responses arrive in tag order 0..4; start gap >=1 cycle between ops.
- Push no_op tag=7 -> response with result 0 and tag 7; alu_start never asserted.
- Assert reset while in ISSUE with 2 commands queued -> next cycle alu_start=0, rsp_valid=0, cmd_count=0, and no response is ever produced.
- With ALU_CMD_TIMEOUT_EN and TIMEOUT=64, never assert done -> after 64 cycles rsp_err=1, rsp_result=0, and alu_start=0; the next command then issues normally.
